// File: rtl/spi_flash_cmd_if.sv
// Bus bundle between the SPI front end, the byte-wide memory read port and spi_flash_cmd.
// master = environment (front end + memory), slave = the command decoder.
interface spi_flash_cmd_if #(
   parameter int ADDR_WIDTH = 24
);
   logic                  spi_cs;
   logic                  rx_strobe;
   logic [7:0]            rx_data;
   logic                  tx_strobe;
   logic [7:0]            tx_data;
   logic                  mem_rd_strobe;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd_valid;
   logic [7:0]            mem_rd_data;
   logic                  cmd_strobe;
   logic [7:0]            cmd;

   modport master (
      output spi_cs, rx_strobe, rx_data, mem_rd_valid, mem_rd_data,
      input  tx_strobe, tx_data, mem_rd_strobe, mem_addr, cmd_strobe, cmd
   );

   modport slave (
      input  spi_cs, rx_strobe, rx_data, mem_rd_valid, mem_rd_data,
      output tx_strobe, tx_data, mem_rd_strobe, mem_addr, cmd_strobe, cmd
   );
endinterface

// File: rtl/spi_flash_cmd.sv
// SPI-NOR command decoder (READ, JEDEC ID, READ STATUS) with a one-byte read prefetch buffer.
// Define SPI_FLASH_FAST_READ_EN to also decode FAST READ (0x0B) with one dummy byte.
module spi_flash_cmd #(
   parameter int          ADDR_WIDTH = 24,
   parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
   parameter logic [7:0]  STATUS_VAL = 8'h00
) (
   input logic            mclk,
   input logic            reset,
   spi_flash_cmd_if.slave bus
);

   typedef enum logic [2:0] {
      S_CMD,
      S_ADDR,
      S_DATA,
      S_ID,
      S_STAT,
      S_IGNORE
`ifdef SPI_FLASH_FAST_READ_EN
      , S_DUMMY
`endif
   } state_t;

   state_t      state;
   logic [1:0]  byte_cnt;
   logic [15:0] addr_hi;
   logic [7:0]  buf_data;
   logic        buf_full;
   logic        need_byte;
   logic        rd_pending;
   logic [1:0]  id_cnt;
`ifdef SPI_FLASH_FAST_READ_EN
   logic        fast_read;
`endif

   logic        valid_in;
   logic        in_data;
   logic        in_dummy;
   logic        serve_buf;
   logic        serve_byp;
   logic [23:0] addr_full;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      valid_in  = bus.mem_rd_valid && rd_pending;
      in_data   = (state == S_DATA);
`ifdef SPI_FLASH_FAST_READ_EN
      in_dummy  = (state == S_DUMMY);
`else
      in_dummy  = 1'b0;
`endif
      // Buffered byte goes out when the shifter asks; a pending ask is served straight from memory.
      serve_buf = buf_full && ((in_data && (need_byte || bus.rx_strobe)) ||
                               (in_dummy && bus.rx_strobe));
      serve_byp = in_data && need_byte && valid_in && !bus.rx_strobe;
      addr_full = {addr_hi, bus.rx_data};
   end

   // NOTE: sequential state uses non-blocking assignments only; later assignments in the block win.
   always_ff @(posedge mclk) begin
      if (reset) begin
         state             <= S_CMD;
         byte_cnt          <= 2'd0;
         addr_hi           <= 16'h0000;
         buf_data          <= 8'h00;
         buf_full          <= 1'b0;
         need_byte         <= 1'b0;
         rd_pending        <= 1'b0;
         id_cnt            <= 2'd0;
`ifdef SPI_FLASH_FAST_READ_EN
         fast_read         <= 1'b0;
`endif
         bus.tx_strobe     <= 1'b0;
         bus.tx_data       <= 8'hFF;
         bus.mem_rd_strobe <= 1'b0;
         bus.mem_addr      <= '0;
         bus.cmd_strobe    <= 1'b0;
         bus.cmd           <= 8'h00;
      end else begin
         bus.tx_strobe     <= 1'b0;
         bus.mem_rd_strobe <= 1'b0;
         bus.cmd_strobe    <= 1'b0;

         if (bus.spi_cs) begin
            // Deselect drops the current byte and any read still in flight.
            state      <= S_CMD;
            byte_cnt   <= 2'd0;
            buf_full   <= 1'b0;
            need_byte  <= 1'b0;
            rd_pending <= 1'b0;
            id_cnt     <= 2'd0;
         end else begin
            if (serve_buf || serve_byp) begin
               bus.tx_strobe     <= 1'b1;
               bus.tx_data       <= serve_buf ? buf_data : bus.mem_rd_data;
               buf_full          <= 1'b0;
               need_byte         <= 1'b0;
               bus.mem_addr      <= bus.mem_addr + ADDR_WIDTH'(1);
               bus.mem_rd_strobe <= 1'b1;
               rd_pending        <= 1'b1;
            end else if (valid_in) begin
               buf_data   <= bus.mem_rd_data;
               buf_full   <= 1'b1;
               rd_pending <= 1'b0;
            end

            case (state)
               S_CMD: begin
                  byte_cnt <= 2'd0;
                  id_cnt   <= 2'd0;
                  if (bus.rx_strobe) begin
                     bus.cmd        <= bus.rx_data;
                     bus.cmd_strobe <= 1'b1;
                     case (bus.rx_data)
                        8'h03: begin
                           state <= S_ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
                           fast_read <= 1'b0;
`endif
                        end
`ifdef SPI_FLASH_FAST_READ_EN
                        8'h0B: begin
                           state     <= S_ADDR;
                           fast_read <= 1'b1;
                        end
`endif
                        8'h9F: begin
                           state         <= S_ID;
                           bus.tx_strobe <= 1'b1;
                           bus.tx_data   <= JEDEC_ID[23:16];
                        end
                        8'h05: begin
                           state         <= S_STAT;
                           bus.tx_strobe <= 1'b1;
                           bus.tx_data   <= STATUS_VAL;
                        end
                        default: state <= S_IGNORE;
                     endcase
                  end
               end

               S_ADDR: begin
                  if (bus.rx_strobe) begin
                     addr_hi  <= {addr_hi[7:0], bus.rx_data};
                     byte_cnt <= byte_cnt + 2'd1;
                     if (byte_cnt == 2'd2) begin
                        bus.mem_addr      <= addr_full[ADDR_WIDTH-1:0];
                        bus.mem_rd_strobe <= 1'b1;
                        rd_pending        <= 1'b1;
`ifdef SPI_FLASH_FAST_READ_EN
                        need_byte <= !fast_read;
                        state     <= fast_read ? S_DUMMY : S_DATA;
`else
                        need_byte <= 1'b1;
                        state     <= S_DATA;
`endif
                     end
                  end
               end

`ifdef SPI_FLASH_FAST_READ_EN
               S_DUMMY: begin
                  if (bus.rx_strobe) begin
                     state <= S_DATA;
                     if (!buf_full) need_byte <= 1'b1;
                  end
               end
`endif

               S_DATA: begin
                  if (bus.rx_strobe && !serve_buf) need_byte <= 1'b1;
               end

               S_ID: begin
                  if (bus.rx_strobe) begin
                     bus.tx_strobe <= 1'b1;
                     case (id_cnt)
                        2'd0:    bus.tx_data <= JEDEC_ID[15:8];
                        2'd1:    bus.tx_data <= JEDEC_ID[7:0];
                        default: bus.tx_data <= 8'hFF;
                     endcase
                     if (id_cnt != 2'd2) id_cnt <= id_cnt + 2'd1;
                  end
               end

               S_STAT: begin
                  if (bus.rx_strobe) begin
                     bus.tx_strobe <= 1'b1;
                     bus.tx_data   <= STATUS_VAL;
                  end
               end

               S_IGNORE: ;

               default: state <= S_CMD;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_cmd.sv
// Scoreboard bench for spi_flash_cmd: directed command streams, a fixed-latency memory model
// returning addr[7:0], and a monitor that checks every strobe against queued expectations.
module tb_spi_flash_cmd;
   localparam int AW      = 24;
   localparam int MEM_LAT = 2;

   logic mclk  = 1'b0;
   logic reset = 1'b1;

   spi_flash_cmd_if #(.ADDR_WIDTH(AW)) bus ();

   spi_flash_cmd #(
      .ADDR_WIDTH(AW),
      .JEDEC_ID  (24'hEF4018),
      .STATUS_VAL(8'h00)
   ) dut (
      .mclk (mclk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 mclk = ~mclk;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  exp_tx[$];
   logic [23:0] exp_addr[$];
   logic [7:0]  exp_cmd[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic send(input logic [7:0] b, input int gap = 15);
      @(negedge mclk);
      bus.rx_strobe = 1'b1;
      bus.rx_data   = b;
      @(negedge mclk);
      bus.rx_strobe = 1'b0;
      repeat (gap) @(negedge mclk);
   endtask

   task automatic deselect();
      bus.spi_cs = 1'b1;
      repeat (6) @(negedge mclk);
      bus.spi_cs = 1'b0;
      repeat (2) @(negedge mclk);
   endtask

   task automatic drain(input string name);
      check({name, "_tx_left"},   exp_tx.size(),   0);
      check({name, "_addr_left"}, exp_addr.size(), 0);
      check({name, "_cmd_left"},  exp_cmd.size(),  0);
   endtask

   // Memory model: fixed latency, data = low address byte.
   initial begin
      logic [23:0] a;
      int cnt;
      a   = '0;
      cnt = 0;
      bus.mem_rd_valid = 1'b0;
      bus.mem_rd_data  = 8'h00;
      forever begin
         @(negedge mclk);
         bus.mem_rd_valid = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               bus.mem_rd_valid = 1'b1;
               bus.mem_rd_data  = a[7:0];
            end
         end
         if (bus.mem_rd_strobe) begin
            a   = bus.mem_addr;
            cnt = MEM_LAT - 1;
         end
      end
   end

   // Monitor: inputs seen here are the ones the DUT sampled on this edge's predecessor cycle.
   initial begin
      forever begin
         @(posedge mclk);
         #1;
         if (!reset) begin
            if (bus.cmd_strobe) begin
               check("cmd_expected", exp_cmd.size() != 0, 1);
               if (exp_cmd.size() != 0) check("cmd", bus.cmd, exp_cmd.pop_front());
               check("cmd_latency", bus.rx_strobe, 1);
            end
            if (bus.tx_strobe) begin
               check("tx_expected", exp_tx.size() != 0, 1);
               if (exp_tx.size() != 0) check("tx_data", bus.tx_data, exp_tx.pop_front());
               check("tx_latency", bus.rx_strobe | bus.mem_rd_valid, 1);
            end
            if (bus.mem_rd_strobe) begin
               check("rd_expected", exp_addr.size() != 0, 1);
               if (exp_addr.size() != 0) check("mem_addr", bus.mem_addr, exp_addr.pop_front());
            end
         end
      end
   end

   initial begin
      #1000000;
      n_errors++;
      $display("FAIL watchdog: run did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      bus.spi_cs    = 1'b1;
      bus.rx_strobe = 1'b0;
      bus.rx_data   = 8'h00;
      repeat (3) @(negedge mclk);
      check("rst_tx_strobe", bus.tx_strobe, 0);
      check("rst_tx_data",   bus.tx_data, 8'hFF);
      check("rst_mem_rd",    bus.mem_rd_strobe, 0);
      check("rst_mem_addr",  bus.mem_addr, 0);
      check("rst_cmd_strobe", bus.cmd_strobe, 0);
      check("rst_cmd",       bus.cmd, 0);
      reset = 1'b0;
      repeat (2) @(negedge mclk);
      bus.spi_cs = 1'b0;
      repeat (2) @(negedge mclk);

      // JEDEC ID: EF 40 18 then FF forever.
      exp_cmd.push_back(8'h9F);
      exp_tx = '{8'hEF, 8'h40, 8'h18, 8'hFF, 8'hFF};
      send(8'h9F); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
      deselect();
      drain("jedec");

      // READ at 0x000100, four bytes out, refill request for 0x000104.
      exp_cmd.push_back(8'h03);
      exp_addr = '{24'h000100, 24'h000101, 24'h000102, 24'h000103, 24'h000104};
      exp_tx   = '{8'h00, 8'h01, 8'h02, 8'h03};
      send(8'h03); send(8'h00); send(8'h01); send(8'h00);
      send(8'h00); send(8'h00); send(8'h00);
      deselect();
      drain("read");

      // Address wrap at the top of the 24-bit space.
      exp_cmd.push_back(8'h03);
      exp_addr = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
      exp_tx   = '{8'hFE, 8'hFF, 8'h00};
      send(8'h03); send(8'hFF); send(8'hFF); send(8'hFE);
      send(8'h00); send(8'h00);
      deselect();
      drain("wrap");

      // Deselect right after the second data byte; the 0x2A3 data must never appear.
      exp_cmd.push_back(8'h03);
      exp_addr = '{24'h0002A0, 24'h0002A1, 24'h0002A2, 24'h0002A3};
      exp_tx   = '{8'hA0, 8'hA1, 8'hA2};
      send(8'h03); send(8'h00); send(8'h02); send(8'hA0);
      send(8'h00); send(8'h00, 0);
      deselect();
      drain("desel");
      exp_cmd.push_back(8'h05);
      exp_tx = '{8'h00, 8'h00};
      send(8'h05); send(8'h33);
      deselect();
      drain("status");

      // Unknown command is swallowed silently.
      exp_cmd.push_back(8'h5A);
      send(8'h5A); send(8'h01); send(8'h02); send(8'h03);
      check("unknown_cmd", bus.cmd, 8'h5A);
      deselect();
      drain("unknown");

      // FAST READ: served only when the feature is built in.
      exp_cmd.push_back(8'h0B);
`ifdef SPI_FLASH_FAST_READ_EN
      exp_addr = '{24'h000010, 24'h000011, 24'h000012};
      exp_tx   = '{8'h10, 8'h11};
`endif
      send(8'h0B); send(8'h00); send(8'h00); send(8'h10); send(8'hDD);
      send(8'h00);
      deselect();
      drain("fast");

      // Reset while a read is in flight: outputs return to reset values, late data ignored.
      exp_cmd.push_back(8'h03);
      exp_addr = '{24'h000005};
      send(8'h03); send(8'h00); send(8'h00); send(8'h05, 0);
      reset = 1'b1;
      @(negedge mclk);
      check("midrst_tx_data",  bus.tx_data, 8'hFF);
      check("midrst_mem_addr", bus.mem_addr, 0);
      check("midrst_mem_rd",   bus.mem_rd_strobe, 0);
      check("midrst_cmd",      bus.cmd, 0);
      reset = 1'b0;
      repeat (10) @(negedge mclk);
      deselect();
      drain("midrst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
